// File: rtl/life_support_ctrl.sv
// Supervisory controller for the life-support unit: defend/stealth mode FSM with
// minimum hold, cooldown-spaced resupply strobes and a sticky abort on persistent fatal status.
module life_support_ctrl #(
  parameter int unsigned N          = 32,
  parameter int unsigned PWR_FULL   = 1000,
  parameter int unsigned O2_FULL    = 500,
  parameter int unsigned PWR_LOW    = 30,
  parameter int unsigned O2_LOW     = 20,
  parameter int unsigned SHIELD_LOW = 50,
  parameter int unsigned TEMP_HIGH  = 90,
  parameter int unsigned HOLD       = 8,
  parameter int unsigned COOLDOWN   = 16,
  parameter int unsigned FATAL_CNT  = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in_shield,
  input  logic [N-1:0] in_temp,
  input  logic [N-1:0] in_power,
  input  logic [N-1:0] in_o2,
  input  logic         in_fatal,
  input  logic         threat,
  input  logic         stealth_req,
  output logic [3:0]   mode,
  output logic         chrg,
  output logic         o2sup,
  output logic [N-1:0] pwr_val,
  output logic [N-1:0] o2_val,
  output logic         warn,
  output logic         alarm,
  output logic [2:0]   state
);

  localparam int unsigned HW = $clog2(HOLD + 1);
  localparam int unsigned CW = $clog2(COOLDOWN + 1);
  localparam int unsigned FW = $clog2(FATAL_CNT + 1);

  localparam logic [HW-1:0] HOLD_V    = HW'(HOLD);
  localparam logic [CW-1:0] CD_V      = CW'(COOLDOWN);
  localparam logic [FW-1:0] FAT_LAST  = FW'(FATAL_CNT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    NORMAL  = 3'd1,
    DEFEND  = 3'd2,
    STEALTH = 3'd3,
    ABORT   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [FW-1:0] fat_q, fat_d;
  logic [CW-1:0] pwr_cd, o2_cd;
  logic          low_pwr, low_o2, hot, shield_ok, active;

  assign low_pwr   = in_power <  N'(PWR_LOW);
  assign low_o2    = in_o2    <  N'(O2_LOW);
  assign hot       = in_temp  >= N'(TEMP_HIGH);
  assign shield_ok = in_shield >= N'(SHIELD_LOW);
  assign active    = (state_q == NORMAL) || (state_q == DEFEND) || (state_q == STEALTH);

  assign pwr_val = N'(PWR_FULL);
  assign o2_val  = N'(O2_FULL);
  assign state   = state_q;

  function automatic logic [3:0] mode_of(input state_t s);
    case (s)
      DEFEND:  mode_of = 4'b0100;
      STEALTH: mode_of = 4'b1000;
      default: mode_of = 4'b0000;
    endcase
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    hold_d  = (hold_q != '0) ? hold_q - 1'b1 : '0;
    fat_d   = '0;

    case (state_q)
      IDLE: state_d = NORMAL;
      NORMAL: begin
        if (threat) begin
          state_d = DEFEND;
          hold_d  = HOLD_V;
        end else if (stealth_req) begin
          state_d = STEALTH;
          hold_d  = HOLD_V;
        end
      end
      DEFEND: begin
        if (threat)                          hold_d  = HOLD_V;
        else if (hold_q == '0 && shield_ok)  state_d = NORMAL;
      end
      STEALTH: begin
        if (threat) begin
          state_d = DEFEND;
          hold_d  = HOLD_V;
        end else if (hot || (hold_q == '0 && !stealth_req)) begin
          state_d = NORMAL;
        end
      end
      ABORT:   state_d = ABORT;
      default: state_d = IDLE;
    endcase

    // Persistent fatal status wins over any mode transition chosen above.
    if (active && in_fatal) begin
      if (fat_q >= FAT_LAST) state_d = ABORT;
      else                   fat_d   = fat_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; later assignments in the block override defaults.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mode    <= 4'b0000;
      hold_q  <= '0;
      fat_q   <= '0;
      pwr_cd  <= '0;
      o2_cd   <= '0;
      chrg    <= 1'b0;
      o2sup   <= 1'b0;
      warn    <= 1'b0;
      alarm   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode    <= mode_of(state_d);
      hold_q  <= hold_d;
      fat_q   <= fat_d;
      chrg    <= 1'b0;
      o2sup   <= 1'b0;
      pwr_cd  <= (pwr_cd != '0) ? pwr_cd - 1'b1 : '0;
      o2_cd   <= (o2_cd  != '0) ? o2_cd  - 1'b1 : '0;

      if (state_q == IDLE) begin
        chrg   <= 1'b1;
        o2sup  <= 1'b1;
        pwr_cd <= CD_V;
        o2_cd  <= CD_V;
        warn   <= 1'b0;
      end else if (state_d == ABORT) begin
        alarm <= 1'b1;
        warn  <= 1'b1;
      end else begin
        if (low_pwr && pwr_cd == '0) begin
          chrg   <= 1'b1;
          pwr_cd <= CD_V;
        end
        if (low_o2 && o2_cd == '0) begin
          o2sup <= 1'b1;
          o2_cd <= CD_V;
        end
        warn <= low_pwr | low_o2 | hot;
      end
    end
  end

endmodule

// File: tb/tb_life_support_ctrl.sv
// Self-checking bench for life_support_ctrl: directed scenarios plus randomized
// stimulus compared each cycle against a behavioural model of the control rules.
module tb_life_support_ctrl;

  localparam int unsigned N          = 32;
  localparam int unsigned PWR_FULL   = 1000;
  localparam int unsigned O2_FULL    = 500;
  localparam int unsigned PWR_LOW    = 30;
  localparam int unsigned O2_LOW     = 20;
  localparam int unsigned SHIELD_LOW = 50;
  localparam int unsigned TEMP_HIGH  = 90;
  localparam int unsigned HOLD       = 8;
  localparam int unsigned COOLDOWN   = 16;
  localparam int unsigned FATAL_CNT  = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] in_shield, in_temp, in_power, in_o2;
  logic         in_fatal, threat, stealth_req;
  logic [3:0]   mode;
  logic         chrg, o2sup, warn, alarm;
  logic [N-1:0] pwr_val, o2_val;
  logic [2:0]   state;

  int passed = 0;
  int total  = 0;

  // Reference model: mode index (0 idle,1 normal,2 defend,3 stealth,4 abort) and counters as plain ints.
  int         m_st, m_hold, m_fat, m_pcd, m_ocd;
  bit         e_chrg, e_o2sup, e_warn, e_alarm;
  logic [3:0] e_mode;

  life_support_ctrl #(
    .N(N), .PWR_FULL(PWR_FULL), .O2_FULL(O2_FULL), .PWR_LOW(PWR_LOW), .O2_LOW(O2_LOW),
    .SHIELD_LOW(SHIELD_LOW), .TEMP_HIGH(TEMP_HIGH), .HOLD(HOLD), .COOLDOWN(COOLDOWN),
    .FATAL_CNT(FATAL_CNT)
  ) dut (
    .clk(clk), .rst(rst),
    .in_shield(in_shield), .in_temp(in_temp), .in_power(in_power), .in_o2(in_o2),
    .in_fatal(in_fatal), .threat(threat), .stealth_req(stealth_req),
    .mode(mode), .chrg(chrg), .o2sup(o2sup), .pwr_val(pwr_val), .o2_val(o2_val),
    .warn(warn), .alarm(alarm), .state(state)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic model_reset();
    m_st = 0; m_hold = 0; m_fat = 0; m_pcd = 0; m_ocd = 0;
    e_chrg = 0; e_o2sup = 0; e_warn = 0; e_alarm = 0; e_mode = 4'b0000;
  endtask

  task automatic model_update();
    int nst;
    if (!rst) begin
      model_reset();
    end else begin
      e_chrg = 0;
      e_o2sup = 0;
      if (m_st == 0) begin
        m_st = 1; e_chrg = 1; e_o2sup = 1; m_pcd = COOLDOWN; m_ocd = COOLDOWN; e_warn = 0;
      end else if (m_st == 4) begin
        e_warn = 1;
      end else begin
        nst = m_st;
        case (m_st)
          1: begin
            if (threat)           begin nst = 2; m_hold = HOLD; end
            else if (stealth_req) begin nst = 3; m_hold = HOLD; end
          end
          2: begin
            if (!threat && m_hold == 0 && in_shield >= SHIELD_LOW) nst = 1;
            m_hold = threat ? HOLD : (m_hold > 0 ? m_hold - 1 : 0);
          end
          default: begin
            if (threat) begin
              nst = 2; m_hold = HOLD;
            end else begin
              if (in_temp >= TEMP_HIGH || (m_hold == 0 && !stealth_req)) nst = 1;
              m_hold = (m_hold > 0) ? m_hold - 1 : 0;
            end
          end
        endcase
        m_fat = in_fatal ? m_fat + 1 : 0;
        if (m_fat >= FATAL_CNT) nst = 4;
        if (nst == 4) begin
          e_alarm = 1; e_warn = 1;
        end else begin
          if (in_power < PWR_LOW && m_pcd == 0) begin e_chrg = 1; m_pcd = COOLDOWN; end
          else if (m_pcd > 0) m_pcd--;
          if (in_o2 < O2_LOW && m_ocd == 0) begin e_o2sup = 1; m_ocd = COOLDOWN; end
          else if (m_ocd > 0) m_ocd--;
          e_warn = (in_power < PWR_LOW) || (in_o2 < O2_LOW) || (in_temp >= TEMP_HIGH);
        end
        m_st = nst;
      end
      e_mode = (m_st == 2) ? 4'b0100 : (m_st == 3) ? 4'b1000 : 4'b0000;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic set_quiet();
    in_shield = 60; in_temp = 20; in_power = 500; in_o2 = 100;
    in_fatal = 0; threat = 0; stealth_req = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    in_shield = 0; in_temp = 0; in_power = 0; in_o2 = 0;
    in_fatal = 0; threat = 0; stealth_req = 0;
    model_reset();
    #12;
    total++; if (state !== 3'd0) $display("FAIL reset_state got=%0d exp=0", state); else passed++;
    total++; if ({mode, chrg, o2sup, warn, alarm} !== 8'h00)
      $display("FAIL reset_outputs got=%b exp=00000000", {mode, chrg, o2sup, warn, alarm}); else passed++;
    total++; if (pwr_val !== 32'd1000 || o2_val !== 32'd500)
      $display("FAIL reset_vals got=%0d/%0d exp=1000/500", pwr_val, o2_val); else passed++;
    in_fatal = 1;
    rst = 1;
    step();
    total++; if (chrg !== 1'b1 || o2sup !== 1'b1 || state !== 3'd1 || warn !== 1'b0)
      $display("FAIL initial_load got chrg=%b o2sup=%b state=%0d warn=%b exp 1 1 1 0", chrg, o2sup, state, warn); else passed++;
    step();
    total++; if (chrg !== 1'b0 || o2sup !== 1'b0 || mode !== 4'b0000 || alarm !== 1'b0 || warn !== 1'b1)
      $display("FAIL cycle2 got chrg=%b o2sup=%b mode=%b alarm=%b warn=%b exp 0 0 0000 0 1", chrg, o2sup, mode, alarm, warn); else passed++;
    step();
    in_fatal = 0;
    total++; if (alarm !== 1'b0 || state !== 3'd1)
      $display("FAIL idle_fatal_ignored got alarm=%b state=%0d exp 0 1", alarm, state); else passed++;
    step();
  endtask

  task automatic test_recharge();
    bit exp_c;
    rst = 0;
    model_reset();
    #7;
    set_quiet();
    in_power = 10;
    rst = 1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      step();
      exp_c = (cyc == 1 || cyc == 18 || cyc == 35 || cyc == 52);
      total++; if (chrg !== exp_c) $display("FAIL recharge_chrg cyc=%0d got=%b exp=%b", cyc, chrg, exp_c); else passed++;
      total++; if (o2sup !== (cyc == 1)) $display("FAIL recharge_o2sup cyc=%0d got=%b exp=%b", cyc, o2sup, cyc == 1); else passed++;
      if (cyc == 2) begin
        total++; if (warn !== 1'b1) $display("FAIL recharge_warn got=%b exp=1", warn); else passed++;
      end
    end
    in_power = 500;
    for (int cyc = 0; cyc < 40; cyc++) begin
      step();
      total++; if (chrg !== 1'b0) $display("FAIL recharge_stop cyc=%0d got=%b exp=0", cyc, chrg); else passed++;
      if (cyc == 0) begin
        total++; if (warn !== 1'b0) $display("FAIL recharge_warn_clear got=%b exp=0", warn); else passed++;
      end
    end
  endtask

  task automatic test_defend();
    in_shield = 40;
    threat = 1;
    step();
    total++; if (mode !== 4'b0100 || state !== 3'd2)
      $display("FAIL defend_enter got mode=%b state=%0d exp 0100 2", mode, state); else passed++;
    threat = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      total++; if (mode !== 4'b0100) $display("FAIL defend_shield_hold i=%0d got=%b exp=0100", i, mode); else passed++;
    end
    in_shield = 60;
    step();
    total++; if (mode !== 4'b0000 || state !== 3'd1)
      $display("FAIL defend_exit got mode=%b state=%0d exp 0000 1", mode, state); else passed++;
  endtask

  task automatic test_stealth();
    stealth_req = 1;
    step();
    total++; if (mode !== 4'b1000) $display("FAIL stealth_enter got=%b exp=1000", mode); else passed++;
    step(); step();
    in_temp = 95;
    step();
    total++; if (mode !== 4'b0000) $display("FAIL stealth_overheat got=%b exp=0000", mode); else passed++;
    in_temp = 20;
    step();
    total++; if (mode !== 4'b1000) $display("FAIL stealth_reenter got=%b exp=1000", mode); else passed++;
    step(); step();
    threat = 1;
    step();
    total++; if (mode !== 4'b0100) $display("FAIL stealth_threat got=%b exp=0100", mode); else passed++;
    threat = 0;
    stealth_req = 0;
    for (int i = 0; i < 8; i++) step();
    total++; if (mode !== 4'b0100) $display("FAIL defend_min_hold got=%b exp=0100", mode); else passed++;
    step();
    total++; if (mode !== 4'b0000) $display("FAIL defend_hold_expire got=%b exp=0000", mode); else passed++;
    stealth_req = 1;
    step();
    stealth_req = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      total++; if (mode !== 4'b1000) $display("FAIL stealth_min_hold i=%0d got=%b exp=1000", i, mode); else passed++;
    end
    step();
    total++; if (mode !== 4'b0000) $display("FAIL stealth_hold_expire got=%b exp=0000", mode); else passed++;
  endtask

  task automatic test_fatal();
    in_fatal = 1;
    step(); step();
    in_fatal = 0;
    total++; if (alarm !== 1'b0 || state !== 3'd1)
      $display("FAIL fatal_two got alarm=%b state=%0d exp 0 1", alarm, state); else passed++;
    step();
    in_fatal = 1;
    step(); step();
    total++; if (alarm !== 1'b0 || state !== 3'd1)
      $display("FAIL fatal_two_again got alarm=%b state=%0d exp 0 1", alarm, state); else passed++;
    step();
    total++; if (alarm !== 1'b1 || state !== 3'd4 || mode !== 4'b0000 || chrg !== 1'b0 || warn !== 1'b1)
      $display("FAIL fatal_abort got alarm=%b state=%0d mode=%b chrg=%b warn=%b exp 1 4 0000 0 1",
               alarm, state, mode, chrg, warn); else passed++;
    in_fatal = 0;
    for (int i = 0; i < 6; i++) begin
      threat = i[0];
      stealth_req = ~i[0];
      step();
      total++; if (state !== 3'd4 || mode !== 4'b0000 || alarm !== 1'b1)
        $display("FAIL abort_sticky i=%0d got state=%0d mode=%b alarm=%b exp 4 0000 1", i, state, mode, alarm); else passed++;
    end
    #2;
    rst = 0;
    model_reset();
    #1;
    total++; if (state !== 3'd0 || {mode, chrg, o2sup, warn, alarm} !== 8'h00)
      $display("FAIL async_reset got state=%0d outs=%b exp 0 00000000", state, {mode, chrg, o2sup, warn, alarm}); else passed++;
    set_quiet();
    #2;
    rst = 1;
    step();
    total++; if (chrg !== 1'b1 || o2sup !== 1'b1 || state !== 3'd1)
      $display("FAIL reload_after_reset got chrg=%b o2sup=%b state=%0d exp 1 1 1", chrg, o2sup, state); else passed++;
  endtask

  task automatic test_dual();
    stealth_req = 1;
    in_power = 10;
    in_o2 = 5;
    for (int cyc = 2; cyc <= 25; cyc++) begin
      step();
      total++; if (chrg !== (cyc == 18) || o2sup !== (cyc == 18))
        $display("FAIL dual_pulse cyc=%0d got chrg=%b o2sup=%b exp %b", cyc, chrg, o2sup, cyc == 18); else passed++;
      total++; if (mode !== 4'b1000) $display("FAIL dual_mode cyc=%0d got=%b exp=1000", cyc, mode); else passed++;
    end
    set_quiet();
    step();
  endtask

  task automatic test_random();
    int abort_cycles = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ((m_st == 4 && abort_cycles > 20) || $urandom_range(0, 499) == 0) begin
        rst = 0;
        model_reset();
        abort_cycles = 0;
        #1;
        total++; if (state !== 3'd0 || alarm !== 1'b0)
          $display("FAIL rand_reset cyc=%0d got state=%0d alarm=%b exp 0 0", cyc, state, alarm); else passed++;
        rst = 1;
      end
      in_shield = ($urandom_range(0, 7) == 0) ? $urandom() : $urandom_range(0, 120);
      in_temp   = ($urandom_range(0, 7) == 0) ? $urandom() : $urandom_range(0, 120);
      in_power  = ($urandom_range(0, 7) == 0) ? $urandom() : $urandom_range(0, 60);
      in_o2     = ($urandom_range(0, 7) == 0) ? $urandom() : $urandom_range(0, 40);
      in_fatal  = ($urandom_range(0, 5) == 0);
      threat    = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) stealth_req = ~stealth_req;
      step();
      if (m_st == 4) abort_cycles++;
      total++; if (state !== 3'(m_st)) $display("FAIL rand_state cyc=%0d got=%0d exp=%0d", cyc, state, m_st); else passed++;
      total++; if (mode !== e_mode) $display("FAIL rand_mode cyc=%0d got=%b exp=%b", cyc, mode, e_mode); else passed++;
      total++; if (chrg !== e_chrg) $display("FAIL rand_chrg cyc=%0d got=%b exp=%b", cyc, chrg, e_chrg); else passed++;
      total++; if (o2sup !== e_o2sup) $display("FAIL rand_o2sup cyc=%0d got=%b exp=%b", cyc, o2sup, e_o2sup); else passed++;
      total++; if (warn !== e_warn) $display("FAIL rand_warn cyc=%0d got=%b exp=%b", cyc, warn, e_warn); else passed++;
      total++; if (alarm !== e_alarm) $display("FAIL rand_alarm cyc=%0d got=%b exp=%b", cyc, alarm, e_alarm); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_recharge();
    test_defend();
    test_stealth();
    test_fatal();
    test_dual();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/life_support_ctrl.md
Name: life_support_ctrl

Overview:
- Supervisory controller that closes the loop around the life-support unit.
- Consumes its status buses (shield, temperature, power, O2, fatal) and drives its command inputs (mode, chrg, o2sup, and the pwr/o2 reload values).
- Owns the defence/stealth mode FSM with minimum-hold timing, low-resource resupply pulsing with cooldown, and a sticky abort on persistent fatal status.
- Sits between the crew command inputs and the life-support unit.

Parameters:
- N, 32, status/reload bus width
- PWR_FULL, 1000, value driven on pwr_val for recharge loads
- O2_FULL, 500, value driven on o2_val for resupply loads
- PWR_LOW, 30, recharge threshold (in_power < PWR_LOW)
- O2_LOW, 20, resupply threshold (in_o2 < O2_LOW)
- SHIELD_LOW, 50, DEFEND may exit only if in_shield >= SHIELD_LOW
- TEMP_HIGH, 90, overheat threshold (in_temp >= TEMP_HIGH)
- HOLD, 8, minimum cycles in DEFEND/STEALTH
- COOLDOWN, 16, cycles after a chrg/o2sup pulse before the next
- FATAL_CNT, 3, consecutive in_fatal cycles that trigger abort

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_shield  in  N  shield level from life support
- in_temp  in  N  temperature from life support
- in_power  in  N  power level from life support
- in_o2  in  N  O2 level from life support
- in_fatal  in  1  fatal flag from life support
- threat  in  1  attack alert (level)
- stealth_req  in  1  crew stealth request (level)
- mode  out  4  0000 normal, 0100 defend, 1000 stealth
- chrg  out  1  one-cycle power reload strobe
- o2sup  out  1  one-cycle O2 reload strobe
- pwr_val  out  N  constant PWR_FULL
- o2_val  out  N  constant O2_FULL
- warn  out  1  registered low-resource / overheat warning
- alarm  out  1  sticky abort indicator
- state  out  3  FSM state: IDLE=0, NORMAL=1, DEFEND=2, STEALTH=3, ABORT=4

Behaviour:
- Reset (rst=0, async): state=IDLE, mode=0000, chrg=0, o2sup=0, warn=0, alarm=0; hold, fatal and both cooldown counters = 0.
- All outputs are registered. Inputs sampled at edge t are reflected in outputs after edge t (1-cycle latency). mode and state update on the same edge; mode is decoded from the next state.
- Comparisons are unsigned. Counters saturate at 0.
- IDLE: the first edge after rst release sets chrg=1, o2sup=1 (initial load), loads both cooldowns with COOLDOWN, and goes to NORMAL. in_fatal is ignored in IDLE.
- NORMAL:
  - threat -> DEFEND.
  - else stealth_req -> STEALTH.
  - Any entry into DEFEND or STEALTH loads hold=HOLD.
- DEFEND:
  - hold decrements each cycle; threat=1 reloads hold=HOLD.
  - Exit to NORMAL when hold==0 && !threat && in_shield >= SHIELD_LOW; otherwise stay.
- STEALTH, checked in priority order:
  1. threat -> DEFEND immediately (ignores hold; hold reloaded).
  2. in_temp >= TEMP_HIGH -> NORMAL immediately.
  3. hold==0 && !stealth_req -> NORMAL.
- Fatal counter (NORMAL/DEFEND/STEALTH only):
  - Increments on in_fatal=1, clears on in_fatal=0.
  - Reaching FATAL_CNT -> ABORT on that edge; abort overrides every other transition.
- ABORT: mode=0000, chrg=0, o2sup=0, alarm=1. Sticky until rst; no exit otherwise.
- Resupply engine (NORMAL/DEFEND/STEALTH):
  - in_power < PWR_LOW && pwr_cd==0 -> chrg=1 for exactly one cycle, pwr_cd=COOLDOWN.
  - Same for O2: in_o2 < O2_LOW && o2_cd==0 -> o2sup=1 for one cycle, o2_cd=COOLDOWN.
  - Counters decrement every cycle otherwise. Minimum pulse spacing is COOLDOWN+1 cycles.
  - chrg and o2sup may pulse in the same cycle.
- warn = (in_power < PWR_LOW) | (in_o2 < O2_LOW) | (in_temp >= TEMP_HIGH), registered. Forced 0 in IDLE, 1 in ABORT.
- pwr_val/o2_val are constant parameter values, valid from reset.
- Reset mid-operation: immediate return to IDLE values; after rst release the initial load pulses are re-issued.

Test Plan:
1. Release rst with all inputs 0 -> cycle 1: chrg=o2sup=1, state 0->1. Cycle 2: chrg=o2sup=0, mode=0000, alarm=0 (fatal ignored in IDLE).
2. NORMAL, in_power=10, in_o2=100, held -> chrg pulses at cycles 18, 35, 52 (17-cycle spacing), o2sup stays 0, warn=1. Raise in_power to 500 -> no further pulses.
3. threat=1 for 1 cycle, in_shield=40 -> mode=0100. Drop threat, in_shield=40 -> stays DEFEND past 8 cycles. Set in_shield=60 -> mode=0000 on the next edge.
4. stealth_req=1 -> mode=1000. At hold cycle 3, in_temp=95 -> mode=0000 next edge. Repeat with threat=1 at cycle 3 -> mode=0100 next edge.
5. in_fatal=1 for 2 cycles, then 0, then 1 for 3 cycles -> ABORT only after the third consecutive cycle: alarm=1, mode=0000, state=4. Toggle threat/stealth -> no change. Assert rst -> all outputs reset asynchronously.
6. in_power=10 and in_o2=5 together in STEALTH -> chrg and o2sup both pulse in the same cycle; mode stays 1000.
